instr_fetch: RTL and testbench
==============================

INSTR_FETCH -- requirements
Module: instr_fetch

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000, PC value loaded on reset.
REQ-002 SHALL have parameter EXEC_CYCLES, default 11, cycles each instruction is held for the single-cycle control stage (minimum 2).
REQ-003 SHALL use one clock and an asynchronous, active-high reset.
REQ-004 clk  in  1  rising-edge clock.
REQ-005 reset  in  1  asynchronous active-high reset.
REQ-006 pc_enable  in  1  from control; 0 stalls the PC update and holds the current instruction.
REQ-007 branch  in  1  from control; BNE-type conditional branch.
REQ-008 jump  in  1  from control; unconditional jump.
REQ-009 jump_reg  in  1  from control; with jump, target is reg_rs_data.
REQ-010 zero  in  1  ALU zero flag; branch taken when zero==0.
REQ-011 reg_rs_data  in  32  R[rs] from the register file.
REQ-012 imem_req  out  1  instruction memory read request.
REQ-013 imem_addr  out  32  instruction memory byte address (equals pc).
REQ-014 imem_rdata  in  32  instruction word.
REQ-015 imem_valid  in  1  imem_rdata valid this cycle.
REQ-016 instr  out  32  latched instruction register.
REQ-017 op, funct  out  6 each  instr[31:26], instr[5:0].
REQ-018 rs, rt, rd  out  5 each  instr[25:21], instr[20:16], instr[15:11].
REQ-019 imm_se  out  32  instr[15:0] sign-extended.
REQ-020 pc, pc_plus4  out  32 each  current PC and PC+4 (JAL link value).
REQ-021 instr_valid  out  1  instr is valid and being executed.
REQ-022 halted  out  1  halt opcode 6'h3f reached.

Function
REQ-023 SHALL implement FSM states FETCH, EXEC, HALT.
REQ-024 FETCH: imem_req=1, imem_addr=pc; on imem_valid=1 latch imem_rdata into instr same edge, load cycle counter with EXEC_CYCLES-1, go EXEC; imem_valid=0 stays FETCH indefinitely.
REQ-025 EXEC: imem_req=0, instr_valid=1, counter decrements each cycle; imem_valid ignored.
REQ-026 EXEC with counter==0 and pc_enable=1: pc <= next_pc, go FETCH; with pc_enable=0: hold pc, counter and instr, stay EXEC.
REQ-027 next_pc priority: jump&jump_reg -> reg_rs_data; jump -> {pc_plus4[31:28], instr[25:0], 2'b00}; branch&~zero -> pc_plus4 + (imm_se<<2); else pc_plus4.
REQ-028 All PC arithmetic SHALL be modulo 2^32 (wrap 32'hFFFF_FFFC+4 -> 0); no alignment check on reg_rs_data.
REQ-029 Latched op==6'h3f SHALL go HALT instead of EXEC; HALT holds pc and instr, halted=1, instr_valid=0, imem_req=0, exit only by reset.
REQ-030 Latency: instruction issued EXEC_CYCLES cycles after imem_valid; zero-wait memory gives EXEC_CYCLES+1 cycles per instruction.
REQ-031 Decode outputs SHALL be combinational from instr; next_pc sampled only at the EXEC-exit edge.

Reset
REQ-032 reset SHALL force state FETCH, pc=RESET_PC, instr=0, counter=0, instr_valid=0, halted=0 immediately, independent of clk.
REQ-033 Reset mid-FETCH SHALL abandon the outstanding request; a late imem_valid after reset is treated as a response to RESET_PC.
REQ-034 First fetch SHALL begin on the first rising edge after reset deasserts (imem_req=1 during that cycle).

Structure
REQ-035 Opcode constants (6'h3f halt, jump, jal, bne) and FSM state encodings SHALL live in a shared package used by control and fetch.
REQ-036 One sub-module, next_pc_sel (combinational next-PC mux/adder), SHALL be used; everything else inline.

Verification
REQ-037 Reset, imem returns 32'h2008_0005 zero-wait -> imem_addr=0, op=6'h08, rt=8, imm_se=5, pc=4 after 12 cycles.
REQ-038 instr 32'h0800_0010 with jump=1 at pc=0 -> next imem_addr=32'h0000_0040.
REQ-039 BNE imm=16'hFFFF at pc=8, branch=1, zero=0 -> next pc=8; same with zero=1 -> pc=12.
REQ-040 jump=1, jump_reg=1, reg_rs_data=32'h0000_0100 -> next pc=32'h100; pc_enable=0 for 5 cycles at EXEC end -> pc held, instr unchanged.
REQ-041 imem_valid delayed 3 cycles -> imem_req held high 4 cycles, instr unchanged until valid; reset asserted mid-wait -> pc=RESET_PC asynchronously.
REQ-042 imem returns 32'hFC00_0000 -> halted=1 next cycle, imem_req stays 0 for 20 cycles, pc unchanged.

Source files
------------

// File: rtl/instr_fetch_pkg.sv
// Shared definitions for the fetch unit and the control decoder:
// opcode constants, fetch FSM state encoding and a sign-extension helper.
package instr_fetch_pkg;

  localparam logic [5:0] OP_J    = 6'h02;
  localparam logic [5:0] OP_JAL  = 6'h03;
  localparam logic [5:0] OP_BNE  = 6'h05;
  localparam logic [5:0] OP_HALT = 6'h3f;

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    EXEC  = 2'd1,
    HALT  = 2'd2
  } fetch_state_t;

  function automatic logic [31:0] sign_ext16(input logic [15:0] value);
    return {{16{value[15]}}, value};
  endfunction

endpackage

// File: rtl/instr_fetch_next_pc_sel.sv
// Combinational next-PC selection: register jump, absolute jump,
// taken BNE-type branch, or sequential PC+4. All sums wrap modulo 2^32.
module next_pc_sel (
  input  logic [31:0] pc_plus4,
  input  logic [25:0] instr_index,
  input  logic [31:0] imm_se,
  input  logic [31:0] reg_rs_data,
  input  logic        jump,
  input  logic        jump_reg,
  input  logic        branch,
  input  logic        zero,
  output logic [31:0] next_pc
);

  logic [31:0] branch_target;

  assign branch_target = pc_plus4 + {imm_se[29:0], 2'b00};

  // Priority mux: jump via register, then absolute jump, then taken branch.
  always_comb begin
    // NOTE: default assignment first so every path drives next_pc and no latch is inferred.
    next_pc = pc_plus4;
    if (jump && jump_reg) begin
      next_pc = reg_rs_data;
    end else if (jump) begin
      next_pc = {pc_plus4[31:28], instr_index, 2'b00};
    end else if (branch && !zero) begin
      next_pc = branch_target;
    end
  end

endmodule

// File: rtl/instr_fetch.sv
// Multi-cycle instruction fetch unit: requests a word at pc, latches it,
// holds it for EXEC_CYCLES cycles while control executes it, then advances
// pc. A halt opcode parks the unit until reset.
module instr_fetch
  import instr_fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC    = 32'h0000_0000,
  parameter int          EXEC_CYCLES = 11
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        pc_enable,
  input  logic        branch,
  input  logic        jump,
  input  logic        jump_reg,
  input  logic        zero,
  input  logic [31:0] reg_rs_data,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  input  logic        imem_valid,
  output logic [31:0] instr,
  output logic [5:0]  op,
  output logic [5:0]  funct,
  output logic [4:0]  rs,
  output logic [4:0]  rt,
  output logic [4:0]  rd,
  output logic [31:0] imm_se,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4,
  output logic        instr_valid,
  output logic        halted
);

  // EXEC_CYCLES-1 is the largest value the counter ever holds.
  localparam int CNT_W = (EXEC_CYCLES > 2) ? $clog2(EXEC_CYCLES) : 1;

  fetch_state_t     state;
  logic [CNT_W-1:0] cnt;
  logic [31:0]      next_pc;

  // Handshake/status outputs decode straight from the state register, so
  // they change only on clock edges or reset and never follow inputs.
  assign imem_req    = (state == FETCH);
  assign instr_valid = (state == EXEC);
  assign halted      = (state == HALT);
  assign imem_addr   = pc;
  assign pc_plus4    = pc + 32'd4;

  // Field decode of the latched instruction.
  assign op     = instr[31:26];
  assign rs     = instr[25:21];
  assign rt     = instr[20:16];
  assign rd     = instr[15:11];
  assign funct  = instr[5:0];
  assign imm_se = sign_ext16(instr[15:0]);

  next_pc_sel u_next_pc_sel (
    .pc_plus4    (pc_plus4),
    .instr_index (instr[25:0]),
    .imm_se      (imm_se),
    .reg_rs_data (reg_rs_data),
    .jump        (jump),
    .jump_reg    (jump_reg),
    .branch      (branch),
    .zero        (zero),
    .next_pc     (next_pc)
  );

  // Fetch FSM: wait for memory, hold the instruction for the execute window,
  // then advance pc once control allows it.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= FETCH;
      pc    <= RESET_PC;
      instr <= '0;
      cnt   <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      case (state)
        FETCH: begin
          if (imem_valid) begin
            instr <= imem_rdata;
            cnt   <= CNT_W'(EXEC_CYCLES - 1);
            state <= (imem_rdata[31:26] == OP_HALT) ? HALT : EXEC;
          end
        end
        EXEC: begin
          if (cnt != '0) begin
            cnt <= cnt - CNT_W'(1);
          end else if (pc_enable) begin
            pc    <= next_pc;
            state <= FETCH;
          end
        end
        HALT: begin
          // Parked until reset; pc and instr hold.
        end
        default: state <= FETCH;
      endcase
    end
  end

endmodule

// File: tb/tb_instr_fetch.sv
// Self-checking bench for instr_fetch: directed scenarios followed by
// randomized instructions, waits, stalls and control inputs, all checked
// against a transaction-level model of pc and the latched instruction.
module tb_instr_fetch;

  localparam logic [31:0] RESET_PC    = 32'h0000_0000;
  localparam int          EXEC_CYCLES = 11;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        pc_enable = 1'b1;
  logic        branch = 1'b0;
  logic        jump = 1'b0;
  logic        jump_reg = 1'b0;
  logic        zero = 1'b0;
  logic [31:0] reg_rs_data = '0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata = '0;
  logic        imem_valid = 1'b0;
  logic [31:0] instr;
  logic [5:0]  op, funct;
  logic [4:0]  rs, rt, rd;
  logic [31:0] imm_se, pc, pc_plus4;
  logic        instr_valid, halted;

  int checks = 0;
  int errors = 0;
  logic [31:0] exp_pc;

  instr_fetch #(.RESET_PC(RESET_PC), .EXEC_CYCLES(EXEC_CYCLES)) dut (
    .clk         (clk),
    .reset       (reset),
    .pc_enable   (pc_enable),
    .branch      (branch),
    .jump        (jump),
    .jump_reg    (jump_reg),
    .zero        (zero),
    .reg_rs_data (reg_rs_data),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_rdata  (imem_rdata),
    .imem_valid  (imem_valid),
    .instr       (instr),
    .op          (op),
    .funct       (funct),
    .rs          (rs),
    .rt          (rt),
    .rd          (rd),
    .imm_se      (imm_se),
    .pc          (pc),
    .pc_plus4    (pc_plus4),
    .instr_valid (instr_valid),
    .halted      (halted)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference next-pc rule, written from the architectural definition.
  function automatic logic [31:0] model_next_pc(input logic [31:0] cur_pc, input logic [31:0] word,
                                                input logic j, input logic jr, input logic br,
                                                input logic z, input logic [31:0] rsd);
    logic [31:0] seq;
    int          imm;
    seq = cur_pc + 32'd4;
    imm = $signed(word[15:0]);
    if (j && jr) return rsd;
    if (j) return (seq & 32'hF000_0000) | ((word & 32'h03FF_FFFF) << 2);
    if (br && !z) return seq + 32'(imm * 4);
    return seq;
  endfunction

  task automatic check_decode(input logic [31:0] word);
    int imm;
    imm = $signed(word[15:0]);
    check("op",     32'(op),     word >> 26);
    check("rs",     32'(rs),     (word >> 21) & 32'h1f);
    check("rt",     32'(rt),     (word >> 16) & 32'h1f);
    check("rd",     32'(rd),     (word >> 11) & 32'h1f);
    check("funct",  32'(funct),  word & 32'h3f);
    check("imm_se", imm_se,      32'(imm));
  endtask

  task automatic randomize_controls();
    jump        = 1'($urandom);
    jump_reg    = 1'($urandom);
    branch      = 1'($urandom);
    zero        = 1'($urandom);
    reg_rs_data = $urandom;
    imem_valid  = 1'($urandom);
    imem_rdata  = $urandom;
  endtask

  // Asynchronous reset pulse away from the clock edge; checks take effect immediately.
  task automatic apply_reset();
    #3;
    reset = 1'b1;
    #1;
    check("rst_pc",          pc,                RESET_PC);
    check("rst_instr",       instr,             32'h0);
    check("rst_instr_valid", 32'(instr_valid),  32'd0);
    check("rst_halted",      32'(halted),       32'd0);
    @(negedge clk);
    imem_valid = 1'b0;
    pc_enable  = 1'b1;
    reset      = 1'b0;
    #1;
    check("rst_first_req", 32'(imem_req), 32'd1);
    exp_pc = RESET_PC;
  endtask

  // One full instruction: optional memory wait, latch, execute window,
  // optional end-of-window stall, then the pc update.
  task automatic run_instr(input logic [31:0] word, input int waits, input int stalls,
                           input logic j, input logic jr, input logic br, input logic z,
                           input logic [31:0] rsd);
    logic [31:0] old_instr, nxt;
    old_instr = instr;
    check("fetch_req",  32'(imem_req), 32'd1);
    check("fetch_addr", imem_addr,     exp_pc);
    for (int i = 0; i < waits; i++) begin
      imem_valid = 1'b0;
      imem_rdata = $urandom;
      step();
      check("wait_req",   32'(imem_req), 32'd1);
      check("wait_instr", instr,         old_instr);
    end
    imem_valid = 1'b1;
    imem_rdata = word;
    step();
    check("latch_instr", instr,             word);
    check("exec_valid",  32'(instr_valid),  32'd1);
    check("exec_req",    32'(imem_req),     32'd0);
    check("pc_plus4",    pc_plus4,          exp_pc + 32'd4);
    check_decode(word);
    for (int i = 1; i < EXEC_CYCLES; i++) begin
      randomize_controls();
      pc_enable = 1'b1;
      step();
      check("exec_window_valid", 32'(instr_valid), 32'd1);
      check("exec_window_pc",    pc,               exp_pc);
    end
    jump = j; jump_reg = jr; branch = br; zero = z; reg_rs_data = rsd;
    pc_enable = 1'b0;
    for (int s = 0; s < stalls; s++) begin
      imem_valid = 1'($urandom);
      step();
      check("stall_valid", 32'(instr_valid), 32'd1);
      check("stall_pc",    pc,               exp_pc);
      check("stall_instr", instr,            word);
    end
    pc_enable  = 1'b1;
    imem_valid = 1'b0;
    step();
    nxt = model_next_pc(exp_pc, word, j, jr, br, z, rsd);
    check("exit_req",   32'(imem_req),    32'd1);
    check("exit_valid", 32'(instr_valid), 32'd0);
    check("next_pc",    pc,               nxt);
    exp_pc = nxt;
    jump = 1'b0; jump_reg = 1'b0; branch = 1'b0; zero = 1'b0;
  endtask

  task automatic run_halt(input logic [31:0] word);
    check("halt_fetch_addr", imem_addr, exp_pc);
    imem_valid = 1'b1;
    imem_rdata = word;
    step();
    imem_valid = 1'b0;
    check("halted",          32'(halted),      32'd1);
    check("halt_valid",      32'(instr_valid), 32'd0);
    check("halt_req",        32'(imem_req),    32'd0);
    for (int i = 0; i < 20; i++) begin
      randomize_controls();
      pc_enable = 1'($urandom);
      step();
      check("halt_hold_req",   32'(imem_req), 32'd0);
      check("halt_hold_pc",    pc,            exp_pc);
      check("halt_hold_instr", instr,         word);
      check("halt_hold_flag",  32'(halted),   32'd1);
    end
  endtask

  initial begin
    logic [31:0] word;
    exp_pc = RESET_PC;
    #2;
    apply_reset();

    // Zero-wait ADDI-style word: decode fields and pc after 12 cycles.
    run_instr(32'h2008_0005, 0, 0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);

    // Absolute jump from pc 0.
    apply_reset();
    run_instr(32'h0800_0010, 0, 0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0);

    // BNE with imm -1 at pc 8: taken loops to itself, not taken falls through.
    apply_reset();
    run_instr(32'h0000_0000, 0, 0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    run_instr(32'h0000_0000, 0, 0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    run_instr(32'h1509_FFFF, 0, 0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0);
    run_instr(32'h1509_FFFF, 0, 0, 1'b0, 1'b0, 1'b1, 1'b1, 32'h0);

    // Register jump with a 5-cycle stall at the end of the execute window.
    run_instr(32'h0100_0008, 0, 5, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0000_0100);

    // Memory response delayed by 3 cycles.
    run_instr(32'h0123_4567, 3, 0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);

    // Reset while waiting on memory; the late response belongs to RESET_PC.
    imem_valid = 1'b0;
    step();
    step();
    apply_reset();
    run_instr(32'h2129_0003, 0, 0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);

    // Randomized instruction stream.
    for (int n = 0; n < 40; n++) begin
      word = $urandom;
      if (word[31:26] == 6'h3f) word[31:26] = 6'h00;
      run_instr(word, $urandom_range(0, 3), $urandom_range(0, 3),
                1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), $urandom);
    end

    // Reset in the middle of an execute window.
    imem_valid = 1'b1;
    imem_rdata = 32'h0000_0020;
    step();
    imem_valid = 1'b0;
    step();
    step();
    apply_reset();

    // Halt opcode, then recovery only through reset.
    run_instr(32'h0000_0000, 0, 0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    run_halt(32'hFC00_0000);
    apply_reset();
    run_instr(32'h2008_0005, 1, 0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
